// File: rtl/recursive_doubling_subtractor.sv
// Pipelined D = A - B (A + ~B + 1) with a recursive-doubling KGP carry network.
// One register stage per doubling level; operands travel with their KGP data.
module recursive_doubling_subtractor #(
   parameter int WIDTH  = 64,
   parameter int LEVELS = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   output logic [WIDTH-1:0] D,
   output logic             borrow,
   output logic             ovf
);

   // Symbol is {a, ~b}: 00 kill, 11 generate, 01/10 propagate.
   localparam logic [1:0] KGP_GEN = 2'b11;

   typedef logic [WIDTH-1:0][1:0] kgp_vec_t;

   function automatic logic [1:0] kgp_merge(
      input logic [1:0] hi,
      input logic [1:0] lo
   );
      return (hi[1] ^ hi[0]) ? lo : hi;
   endfunction

   kgp_vec_t         kgp_q [LEVELS+1];
   kgp_vec_t         kgp_d [LEVELS+1];
   logic [WIDTH-1:0] a_q   [LEVELS+1];
   logic [WIDTH-1:0] a_d   [LEVELS+1];
   logic [WIDTH-1:0] b_q   [LEVELS+1];
   logic [WIDTH-1:0] b_d   [LEVELS+1];
   logic [LEVELS:0]  v_q;
   logic [LEVELS:0]  v_d;

   logic [WIDTH-1:0] c_q;
   logic [WIDTH-1:0] c_d;
   logic [WIDTH-1:0] ca_q;
   logic [WIDTH-1:0] ca_d;
   logic [WIDTH-1:0] cb_q;
   logic [WIDTH-1:0] cb_d;
   logic             cv_q;
   logic             cv_d;

   logic [WIDTH-1:0] diff;

   always_comb begin : prefix_levels
      for (int k = 0; k <= LEVELS; k++) begin
         kgp_d[k] = '0;
         a_d[k]   = '0;
         b_d[k]   = '0;
      end
      v_d = '0;

      for (int i = 0; i < WIDTH; i++) begin
         kgp_d[0][i] = {A[i], ~B[i]};
      end
      a_d[0] = A;
      b_d[0] = B;
      v_d[0] = in_valid;

      // Lanes whose partner falls below bit 0 pick up the carry-in generate.
      for (int k = 1; k <= LEVELS; k++) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (i >= (1 << (k - 1))) begin
               kgp_d[k][i] = kgp_merge(kgp_q[k-1][i],
                                       kgp_q[k-1][i - (1 << (k - 1))]);
            end else begin
               kgp_d[k][i] = kgp_merge(kgp_q[k-1][i], KGP_GEN);
            end
         end
         a_d[k] = a_q[k-1];
         b_d[k] = b_q[k-1];
         v_d[k] = v_q[k-1];
      end
   end

   // The top lane's window stops at bit 0, so close it against the carry-in.
   always_comb begin : carry_resolve
      c_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         c_d[i] = (kgp_merge(kgp_q[LEVELS][i], KGP_GEN) == KGP_GEN);
      end
      ca_d = a_q[LEVELS];
      cb_d = b_q[LEVELS];
      cv_d = v_q[LEVELS];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         kgp_q <= '{default: '0};
         a_q   <= '{default: '0};
         b_q   <= '{default: '0};
         v_q   <= '0;
         c_q   <= '0;
         ca_q  <= '0;
         cb_q  <= '0;
         cv_q  <= 1'b0;
      end else if (en) begin
         kgp_q <= kgp_d;
         a_q   <= a_d;
         b_q   <= b_d;
         v_q   <= v_d;
         c_q   <= c_d;
         ca_q  <= ca_d;
         cb_q  <= cb_d;
         cv_q  <= cv_d;
      end
   end

   // Results are forced to 0 in empty slots so idle outputs stay deterministic.
   always_comb begin : result
      diff      = ca_q ^ ~cb_q ^ {c_q[WIDTH-2:0], 1'b1};
      out_valid = cv_q;
      D         = cv_q ? diff : '0;
      borrow    = cv_q & ~c_q[WIDTH-1];
      ovf       = cv_q & (ca_q[WIDTH-1] ^ cb_q[WIDTH-1])
                       & (diff[WIDTH-1] ^ ca_q[WIDTH-1]);
   end

endmodule

// File: tb/tb_recursive_doubling_subtractor.sv
// Directed-vector bench for recursive_doubling_subtractor (WIDTH 64).
// Table vectors plus hand sequences for latency, stall, bubble and reset.
module tb_recursive_doubling_subtractor;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] d;
      logic        br;
      logic        ov;
   } vec_t;

   typedef struct packed {
      logic [63:0] d;
      logic        br;
      logic        ov;
   } exp_t;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic        en       = 1'b0;
   logic        in_valid = 1'b0;
   logic [63:0] A        = '0;
   logic [63:0] B        = '0;
   logic        out_valid;
   logic [63:0] D;
   logic        borrow;
   logic        ovf;

   int   n_vec;
   int   n_miss;
   bit   mon_on;
   int   seen;
   int   slot;
   int   first_slot;
   int   last_slot;
   exp_t exp_q[$];
   vec_t tbl[12];

   always #5 clk = ~clk;

   recursive_doubling_subtractor #(.WIDTH(64), .LEVELS(6)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .in_valid (in_valid),
      .A        (A),
      .B        (B),
      .out_valid(out_valid),
      .D        (D),
      .borrow   (borrow),
      .ovf      (ovf)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b, want %b", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      e.d  = a - b;
      e.br = (a < b);
      e.ov = (a[63] != b[63]) && (e.d[63] != a[63]);
      return e;
   endfunction

   // One clock; outputs sampled on the falling edge and scored in order.
   task automatic tick();
      logic e_was;
      exp_t x;
      e_was = en;
      @(posedge clk);
      @(negedge clk);
      if (mon_on && e_was) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk1("unexpected_out_valid", out_valid, 1'b0);
            end else begin
               x = exp_q.pop_front();
               chk("D", D, x.d);
               chk1("borrow", borrow, x.br);
               chk1("ovf", ovf, x.ov);
            end
            if (seen == 0) first_slot = slot;
            last_slot = slot;
            seen++;
         end
         slot++;
      end
   endtask

   task automatic push_exp(input logic [63:0] a, input logic [63:0] b,
                           input exp_t e);
      A        = a;
      B        = b;
      in_valid = 1'b1;
      exp_q.push_back(e);
      tick();
   endtask

   task automatic push(input logic [63:0] a, input logic [63:0] b);
      push_exp(a, b, model(a, b));
   endtask

   task automatic clear_stats();
      seen       = 0;
      slot       = 0;
      first_slot = 0;
      last_slot  = 0;
   endtask

   task automatic drain(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
      chk_int("queue_empty", exp_q.size(), 0);
   endtask

   task automatic run_check(input string nm, input int n_exp, input int gaps);
      chk_int({nm, "_count"}, seen, n_exp);
      chk_int({nm, "_gaps"}, last_slot - first_slot + 1 - seen, gaps);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] sd;
      logic        sv;
      logic        sb;
      logic        so;
      exp_t        e;

      tbl[0]  = '{64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
      tbl[1]  = '{64'h8000_0000_0000_0000, 64'h1,
                  64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
      tbl[2]  = '{64'h0, 64'h0000_0001_0000_0000,
                  64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0};
      tbl[3]  = '{64'h0000_0001_0000_0000, 64'h1,
                  64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0};
      tbl[4]  = '{64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567,
                  64'h0, 1'b0, 1'b0};
      tbl[5]  = '{64'h1234_5678_9ABC_DEF0, 64'h0,
                  64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0};
      tbl[6]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h8000_0000_0000_0000, 1'b1, 1'b1};
      tbl[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h0, 1'b0, 1'b0};
      tbl[8]  = '{64'h0, 64'h0, 64'h0, 1'b0, 1'b0};
      tbl[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      tbl[10] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 1'b0};
      tbl[11] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
                  64'h1, 1'b0, 1'b1};

      n_vec  = 0;
      n_miss = 0;
      mon_on = 1'b0;
      clear_stats();

      // Reset state and single-operation latency.
      #1 reset = 1'b0;
      repeat (3) tick();
      chk1("rst_out_valid", out_valid, 1'b0);
      chk("rst_D", D, 64'h0);
      chk1("rst_borrow", borrow, 1'b0);
      chk1("rst_ovf", ovf, 1'b0);
      reset = 1'b1;
      en    = 1'b1;
      tick();
      A        = 64'd5;
      B        = 64'd3;
      in_valid = 1'b1;
      for (int e_n = 1; e_n <= 10; e_n++) begin
         tick();
         if (e_n == 1) in_valid = 1'b0;
         chk1($sformatf("lat_valid_edge%0d", e_n), out_valid, e_n == 8);
         if (e_n == 8) begin
            chk("lat_D", D, 64'd2);
            chk1("lat_borrow", borrow, 1'b0);
            chk1("lat_ovf", ovf, 1'b0);
         end
      end

      // Hand-computed table, back to back.
      mon_on = 1'b1;
      clear_stats();
      for (int i = 0; i < 12; i++) begin
         e.d  = tbl[i].d;
         e.br = tbl[i].br;
         e.ov = tbl[i].ov;
         push_exp(tbl[i].a, tbl[i].b, e);
      end
      drain(12);
      run_check("table", 12, 0);

      // Twenty back-to-back pairs including A = B and B = 0.
      clear_stats();
      for (int i = 0; i < 20; i++) begin
         a = rnd64();
         b = (i == 5) ? a : (i == 11) ? 64'h0 : rnd64();
         push(a, b);
      end
      drain(12);
      run_check("stream", 20, 0);

      // Bubble plus a 3-cycle stall with junk on the inputs.
      clear_stats();
      for (int i = 0; i < 7; i++) push(rnd64(), rnd64());
      in_valid = 1'b0;
      tick();
      push(rnd64(), rnd64());
      chk1("pre_stall_valid", out_valid, 1'b1);
      sd = D;
      sv = out_valid;
      sb = borrow;
      so = ovf;
      en = 1'b0;
      in_valid = 1'b1;
      A = rnd64();
      B = rnd64();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_D", D, sd);
         chk1("stall_valid", out_valid, sv);
         chk1("stall_borrow", borrow, sb);
         chk1("stall_ovf", ovf, so);
      end
      en = 1'b1;
      push(rnd64(), rnd64());
      push(rnd64(), rnd64());
      drain(12);
      run_check("stall", 10, 1);

      // en toggling every cycle.
      clear_stats();
      for (int i = 0; i < 4; i++) begin
         push(rnd64(), rnd64());
         en = 1'b0;
         A  = rnd64();
         B  = rnd64();
         tick();
         en = 1'b1;
      end
      in_valid = 1'b0;
      repeat (10) begin
         en = 1'b1;
         tick();
         en = 1'b0;
         tick();
      end
      en = 1'b1;
      chk_int("toggle_queue_empty", exp_q.size(), 0);
      run_check("toggle", 4, 0);

      // Asynchronous reset with operations in flight; en low too.
      mon_on = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 9; i++) begin
         A = rnd64();
         B = rnd64();
         in_valid = 1'b1;
         tick();
      end
      chk1("inflight_valid", out_valid, 1'b1);
      #2;
      reset = 1'b0;
      en    = 1'b0;
      #1;
      chk1("async_rst_valid", out_valid, 1'b0);
      chk("async_rst_D", D, 64'h0);
      chk1("async_rst_borrow", borrow, 1'b0);
      chk1("async_rst_ovf", ovf, 1'b0);
      tick();
      tick();
      chk1("rst_hold_valid", out_valid, 1'b0);
      reset    = 1'b1;
      en       = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk1($sformatf("post_rst_valid%0d", i), out_valid, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/recursive_doubling_subtractor.md
Name: recursive_doubling_subtractor

Overview:
- Pipelined WIDTH-bit unsigned/two's-complement subtractor D = A - B, computed as A + ~B + 1.
- Carry propagation uses the recursive-doubling KGP prefix network, with one register stage per doubling level.
- It is the inverse-operation companion to the team's recursive-doubling adder and uses the same kill/generate/propagate encoding.
- Operands travel down the pipeline alongside the KGP data, so the final XOR always uses the operands that belong to that result.

Parameters:
- WIDTH, 64, operand width; must be a power of two and at least 2.
- LEVELS, 6, number of doubling levels; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  pipeline advance enable; 0 freezes every stage.
- in_valid  input  1  A/B valid this cycle.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- out_valid  output  1  D/borrow/ovf valid.
- D  output  WIDTH  A - B modulo 2^WIDTH.
- borrow  output  1  1 when A < B unsigned; equals the inverted final carry.
- ovf  output  1  signed overflow: A[MSB] != B[MSB] and D[MSB] != A[MSB].

Behaviour:

Reset:
- reset low clears every pipeline register asynchronously, including all valid bits, D, borrow and ovf (all 0).
- Release is sampled on the next clk rising edge.
- Reset asserted mid-operation discards all in-flight operations. No stale out_valid appears after release.

Stage structure (all registers update only when en = 1):
- S0 (KGP): per bit i, encode A[i] with ~B[i] as 2 bits: kill = both 0, generate = both 1, propagate = differ.
- S0 bit -1 is a forced generate, which injects the +1 carry-in.
- S0 registers KGP, A, B and in_valid.
- S1..S(LEVELS): level k combines each position i with position i - 2^(k-1) using the standard KGP composition: a propagate takes the lower value, kill or generate holds.
- Positions below the window combine with the forced generate at bit -1.
- Each level registers KGP, A, B and valid.
- S(LEVELS+1) (carry): carry c[i] = 1 iff the resolved KGP at i is generate.
- This stage registers c, A, B and valid.
- Output (combinational from the final register): D[0] = A[0] ^ ~B[0] ^ 1; D[i] = A[i] ^ ~B[i] ^ c[i-1].
- borrow = ~c[WIDTH-1].
- ovf as defined in Ports.

Latency and throughput:
- A pair accepted at rising edge N (in_valid = 1, en = 1) appears with out_valid = 1 after LEVELS + 2 enabled edges, i.e. 8 for WIDTH = 64.
- Throughput is 1 per enabled cycle, with no bubbles between back-to-back operands.

Handshake:
- No backpressure output. The consumer stalls via en.
- en = 0 holds D/borrow/ovf/out_valid stable and ignores in_valid/A/B.
- in_valid = 0 while en = 1 injects a bubble: that slot's out_valid is 0.
- D, borrow and ovf are don't-care when out_valid = 0, but must be deterministic (registers are reset to 0).

Arithmetic edge cases:
- A = B gives D = 0, borrow = 0.
- B = 0 gives D = A, borrow = 0.
- A = 0, B = 1 gives D = all ones, borrow = 1.
- Results wrap modulo 2^WIDTH.

Stall and reset interaction:
- Simultaneous en = 0 and reset low: reset wins.
- en toggling every cycle must still deliver results in order, each exactly once.

Test Plan:
1. Reset low for 3 cycles, then release; drive A = 5, B = 3, in_valid = 1, en = 1 for one cycle -> exactly 8 edges later out_valid = 1, D = 2, borrow = 0, ovf = 0; out_valid = 1 for exactly one cycle.
2. A = 0, B = 1 -> D = 0xFFFF_FFFF_FFFF_FFFF, borrow = 1, ovf = 0. Then A = 0x8000_0000_0000_0000, B = 1 -> D = 0x7FFF_FFFF_FFFF_FFFF, borrow = 0, ovf = 1.
3. Stream 20 back-to-back random pairs, including A = B and B = 0 -> 20 consecutive out_valid cycles, every D equal to (A - B) mod 2^64, in input order.
4. Stream 10 pairs with en deasserted for 3 cycles mid-stream and a bubble (in_valid = 0) inserted -> outputs frozen during the stall, a single out_valid = 0 slot at the bubble position, all results correct and in order.
5. Pulse reset low while 5 operations are in flight -> out_valid = 0 immediately, asynchronously, before any clk edge. After release with no new inputs, out_valid stays 0 for 10 cycles.
6. Carry-chain stress: A = 0x0000_0000_0000_0000 minus B = 0x0000_0001_0000_0000, and A = 0x1_0000_0000 minus B = 1 -> D = 0xFFFF_FFFF_0000_0000 with borrow = 1, and D = 0x0000_0000_FFFF_FFFF with borrow = 0 (a full 32-bit borrow ripple resolved by levels 1-6).
